// File: rtl/icache_dm_param.sv
// icache_dm_param: parametrised direct-mapped, read-only instruction cache.
// Hits are served combinationally from IDLE. A miss fills the whole line from
// memory one word at a time, and the requested word then hits on the cycle
// after the line completes. The flush input invalidates every line.
// Optional build macro ICACHE_STATS_EN adds the hit_count/miss_count outputs.
module icache_dm_param #(
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDXW  = $clog2(SETS);
  localparam int BOFFW = $clog2(BLOCK_WORDS);
  // The word counter keeps at least one bit even for single-word lines.
  localparam int WCW   = (BOFFW == 0) ? 1 : BOFFW;
  localparam int TAGW  = 32 - IDXW - BOFFW - 2;

  typedef enum logic {IDLE, FILL} state_t;

  // Fetch address fields.
  logic [TAGW-1:0] tag_in;
  logic [IDXW-1:0] idx_in;
  logic [WCW-1:0]  woff;

  assign tag_in = imemaddr[31 -: TAGW];
  assign idx_in = imemaddr[BOFFW+2 +: IDXW];

  if (BOFFW > 0) begin : g_woff
    assign woff = imemaddr[2 +: BOFFW];
  end else begin : g_no_woff
    assign woff = '0;
  end

  // The byte-offset bits never select anything in a word-wide cache.
  logic unused_byte_bits;
  assign unused_byte_bits = ^imemaddr[1:0];

  // Control state (reset) and line storage (not reset).
  state_t          state_q, state_d;
  logic [SETS-1:0] valid_q, valid_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [TAGW-1:0] ltag_q;
  logic [IDXW-1:0] lidx_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS][BLOCK_WORDS];

  // Lookup and fill qualifiers.
  logic lookup_hit;
  logic hit;
  logic start_fill;
  logic word_done;
  logic last_word;

  assign lookup_hit = imemREN && valid_q[idx_in] && (tag_q[idx_in] == tag_in);
  assign hit        = (state_q == IDLE) && lookup_hit && !flush;
  assign start_fill = (state_q == IDLE) && imemREN && !lookup_hit && !flush;
  assign word_done  = (state_q == FILL) && !iwait;
  assign last_word  = (wcnt_q == WCW'(BLOCK_WORDS - 1));

  // State register: asynchronous reset returns the FSM to IDLE immediately.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: misses enter FILL, the last word or a flush returns to IDLE.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_fill) state_d = FILL;
      FILL: if (flush || (!iwait && last_word)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: hit data in IDLE, memory request while filling.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = data_q[idx_in][woff];
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {ltag_q, lidx_q, {(BOFFW + 2){1'b0}}} | (32'(wcnt_q) << 2);
      end
      default: ;
    endcase
  end

  // Valid bits and word counter next-state: flush wins over completing a line.
  always_comb begin
    valid_d = valid_q;
    wcnt_d  = wcnt_q;
    if (flush) begin
      valid_d = '0;
      wcnt_d  = '0;
    end else if (start_fill) begin
      // The resident line is evicted as soon as its data starts being overwritten.
      valid_d[idx_in] = 1'b0;
      wcnt_d          = '0;
    end else if (word_done) begin
      if (last_word) begin
        valid_d[lidx_q] = 1'b1;
        wcnt_d          = '0;
      end else begin
        wcnt_d = wcnt_q + WCW'(1);
      end
    end
  end

  // Valid bits and word counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      wcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Line storage: latch the missing line address, capture words, commit the tag.
  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
  // make stale contents unobservable, and resetting wide arrays is costly.
  always_ff @(posedge CLK) begin
    if (start_fill) begin
      ltag_q <= tag_in;
      lidx_q <= idx_in;
    end
    if (word_done) begin
      data_q[lidx_q][wcnt_q] <= iload;
      if (last_word && !flush) tag_q[lidx_q] <= ltag_q;
    end
  end

`ifdef ICACHE_STATS_EN
  // Statistics: count hit cycles and IDLE->FILL transitions; flush leaves them alone.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)        hit_count  <= hit_count + 32'd1;
      if (start_fill) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm_param.sv
// Self-checking bench for icache_dm_param (SETS=16, BLOCK_WORDS=2).
// The reference keeps, per set, which 8-byte line is resident, and derives
// memory contents from a salted hash of the word address.
module tb_icache_dm_param;

  localparam int SETS = 16;
  localparam int BW   = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_dm_param #(.SETS(SETS), .BLOCK_WORDS(BW)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .flush    (flush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] salt;

  // Reference model: resident line number (addr >> 3) per set.
  bit          res_valid [SETS];
  logic [28:0] res_line  [SETS];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = (a >> 3) % SETS;
    return res_valid[s] && (res_line[s] == a[31:3]);
  endfunction

  task automatic model_flush();
    for (int i = 0; i < SETS; i++) res_valid[i] = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_hit_count"},  hit_count,  32'(exp_hits));
    check({tag, "_miss_count"}, miss_count, 32'(exp_misses));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One fetch of address a starting just after a rising edge. Misses are
  // filled with a random number of wait cycles per word in [wmin, wmax];
  // disturb scrambles imemREN/imemaddr during the fill.
  task automatic do_fetch(input logic [31:0] a, input int wmin, input int wmax,
                          input bit disturb);
    logic [31:0] la;
    int          s;
    la = {a[31:3], 3'b000};
    s  = (a >> 3) % SETS;
    imemREN  = 1'b1;
    imemaddr = a;
    flush    = 1'b0;
    iwait    = 1'b1;
    @(negedge CLK);
    if (model_hit(a)) begin
      check("hit_ihit", ihit, 1);
      check("hit_data", imemload, mem_word(a));
      check("hit_iren", iREN, 0);
      exp_hits++;
    end else begin
      check("miss_ihit", ihit, 0);
      check("miss_load", imemload, 0);
      check("miss_iren", iREN, 0);
      exp_misses++;
      @(posedge CLK); #1;
      for (int w = 0; w < BW; w++) begin
        int          nw;
        logic [31:0] wa;
        nw = $urandom_range(wmax, wmin);
        wa = la + 32'(w * 4);
        for (int k = 0; k <= nw; k++) begin
          iwait = (k < nw);
          iload = (k < nw) ? $urandom : mem_word(wa);
          if (disturb) begin
            imemREN  = 1'($urandom_range(1, 0));
            imemaddr = $urandom;
          end
          @(negedge CLK);
          check("fill_iren", iREN, 1);
          check("fill_iaddr", iaddr, wa);
          check("fill_ihit", ihit, 0);
          @(posedge CLK); #1;
        end
      end
      iwait    = 1'b1;
      imemREN  = 1'b1;
      imemaddr = a;
      res_valid[s] = 1'b1;
      res_line[s]  = a[31:3];
      @(negedge CLK);
      check("refill_ihit", ihit, 1);
      check("refill_data", imemload, mem_word(a));
      check("refill_iren", iREN, 0);
      exp_hits++;
    end
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    salt     = $urandom;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    flush    = 1'b0;
    iwait    = 1'b1;
    iload    = '0;
    model_flush();

    // Reset state.
    #12;
    check("rst_ihit", ihit, 0);
    check("rst_iren", iREN, 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_load", imemload, 0);
    check_stats("rst");
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Cold miss on 0x40, then spatial hit on 0x44.
    do_fetch(32'h0000_0040, 0, 0, 1'b0);
    do_fetch(32'h0000_0044, 0, 0, 1'b0);
    check_stats("cold");

    // Conflict: 0x240 shares the set with 0x40.
    do_fetch(32'h0000_0240, 0, 0, 1'b0);
    check("conflict_evicts", 32'(model_hit(32'h0000_0040)), 0);
    do_fetch(32'h0000_0040, 0, 0, 1'b0);

    // Wait states: three waits per word.
    do_fetch(32'h0000_0084, 3, 3, 1'b0);
    do_fetch(32'h0000_0080, 0, 0, 1'b0);

    // Flush in IDLE with a hitting request presented.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    flush    = 1'b1;
    @(negedge CLK);
    check("flush_idle_ihit", ihit, 0);
    check("flush_idle_iren", iREN, 0);
    @(posedge CLK); #1;
    flush   = 1'b0;
    imemREN = 1'b0;
    model_flush();
    do_fetch(32'h0000_0040, 0, 0, 1'b0);

    // Flush during the last fill word, with that word ready: flush wins.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0100;
    @(negedge CLK);
    check("abort_miss_ihit", ihit, 0);
    exp_misses++;
    @(posedge CLK); #1;
    iwait = 1'b0;
    iload = mem_word(32'h0000_0100);
    @(negedge CLK);
    check("abort_w0_iaddr", iaddr, 32'h0000_0100);
    @(posedge CLK); #1;
    flush = 1'b1;
    iload = mem_word(32'h0000_0104);
    @(negedge CLK);
    check("abort_w1_iren", iREN, 1);
    check("abort_w1_iaddr", iaddr, 32'h0000_0104);
    @(posedge CLK); #1;
    flush   = 1'b0;
    iwait   = 1'b1;
    imemREN = 1'b0;
    model_flush();
    @(negedge CLK);
    check("abort_iren_drop", iREN, 0);
    @(posedge CLK); #1;
    do_fetch(32'h0000_0104, 0, 1, 1'b0);
    check_stats("flush");

    // Randomised fetches over a small address pool, with occasional flushes.
    for (int n = 0; n < 80; n++) begin
      a = (32'($urandom_range(1, 0)) << 28) | (32'($urandom_range(3, 0)) << 7) |
          (32'($urandom_range(15, 0)) << 3) | (32'($urandom_range(1, 0)) << 2);
      if ($urandom_range(9, 0) == 0) begin
        flush   = 1'b1;
        imemREN = 1'($urandom_range(1, 0));
        imemaddr = a;
        @(negedge CLK);
        check("rnd_flush_ihit", ihit, 0);
        @(posedge CLK); #1;
        flush   = 1'b0;
        imemREN = 1'b0;
        model_flush();
      end
      do_fetch(a, 0, 2, 1'($urandom_range(1, 0)));
    end
    check_stats("random");

    // Asynchronous reset in the middle of a fill.
    a = 32'h0000_0200;
    if (model_hit(a)) a = 32'h0000_0300 | (a & 32'h0000_0078);
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0208;
    @(posedge CLK); #1;
    imemREN  = 1'b0;
    iwait    = 1'b1;
    @(negedge CLK);
    check("midfill_iren", iREN, model_hit(32'h0000_0208) ? 0 : 1);
    #2;
    nRST = 1'b0;
    #1;
    check("async_rst_iren", iREN, 0);
    check("async_rst_iaddr", iaddr, 0);
    exp_hits   = 0;
    exp_misses = 0;
    check_stats("async_rst");
    model_flush();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    do_fetch(32'h0000_0208, 1, 2, 1'b0);
    do_fetch(32'h0000_020C, 0, 0, 1'b0);
    check_stats("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
